// File: rtl/lbr_record_unit_pkg.sv
// Shared pipeline constants: opcodes seen by decoder/hazard unit and LBR field selects.
package lbr_record_unit_pkg;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] RDLBR = 7'b0001011;

    localparam logic LBR_SEL_FROM = 1'b0;
    localparam logic LBR_SEL_TO   = 1'b1;

endpackage

// File: rtl/lbr_record_unit_ring_ram.sv
// LBR entry storage: one synchronous write port, one combinational read port.
module lbr_ring_ram #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned WIDTH      = 64
) (
    input  logic                  clock,
    input  logic                  write_enable,
    input  logic [INDEX_BITS-1:0] write_index,
    input  logic [WIDTH-1:0]      write_data,
    input  logic [INDEX_BITS-1:0] read_index,
    output logic [WIDTH-1:0]      read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_index] <= write_data;
        end
    end

    assign read_data = mem[read_index];

endmodule

// File: rtl/lbr_record_unit.sv
// Last-branch-record ring: records taken transfers at retire, serves RDLBR reads
// with one cycle of registered latency.
module lbr_record_unit
    import lbr_record_unit_pkg::*;
#(
    parameter int unsigned ADDRESS_BITS = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned INDEX_BITS   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    record_valid,
    input  logic                    record_taken,
    input  logic                    record_stall,
    input  logic [ADDRESS_BITS-1:0] record_from_pc,
    input  logic [ADDRESS_BITS-1:0] record_to_pc,
    input  logic                    lbr_clear,
    input  logic                    read_valid,
    input  logic [INDEX_BITS:0]     read_index,
    input  logic                    read_select,
    output logic [ADDRESS_BITS-1:0] read_data,
    output logic                    read_hit,
    output logic                    read_data_valid,
    output logic [INDEX_BITS:0]     lbr_count
);

    localparam logic [INDEX_BITS:0] FULL_COUNT = (INDEX_BITS + 1)'(DEPTH);

    logic [INDEX_BITS-1:0]     wr_ptr;
    logic [INDEX_BITS:0]       count;
    logic                      record_event;
    logic [INDEX_BITS-1:0]     rd_addr;
    logic [2*ADDRESS_BITS-1:0] rd_word;
    logic [ADDRESS_BITS-1:0]   rd_field;
    logic                      rd_hit;

    assign record_event = record_valid & record_taken & ~record_stall & ~lbr_clear;

    // Age 0 is the slot just behind the write pointer; the top index bit only affects hit.
    assign rd_addr  = wr_ptr - INDEX_BITS'(1) - read_index[INDEX_BITS-1:0];
    assign rd_field = (read_select == LBR_SEL_TO) ? rd_word[ADDRESS_BITS-1:0]
                                                  : rd_word[2*ADDRESS_BITS-1:ADDRESS_BITS];
    assign rd_hit   = (read_index < count);

    lbr_ring_ram #(
        .DEPTH      (DEPTH),
        .INDEX_BITS (INDEX_BITS),
        .WIDTH      (2 * ADDRESS_BITS)
    ) u_ram (
        .clock        (clock),
        .write_enable (record_event),
        .write_index  (wr_ptr),
        .write_data   ({record_from_pc, record_to_pc}),
        .read_index   (rd_addr),
        .read_data    (rd_word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr          <= '0;
            count           <= '0;
            read_data       <= '0;
            read_hit        <= 1'b0;
            read_data_valid <= 1'b0;
        end else begin
            if (lbr_clear) begin
                wr_ptr <= '0;
                count  <= '0;
            end else if (record_event) begin
                wr_ptr <= wr_ptr + INDEX_BITS'(1);
                if (count != FULL_COUNT) begin
                    count <= count + (INDEX_BITS + 1)'(1);
                end
            end

            // Read uses pre-edge pointer/count, so same-cycle record/clear stay invisible.
            read_data_valid <= read_valid;
            if (read_valid) begin
                read_hit  <= rd_hit;
                read_data <= rd_hit ? rd_field : '0;
            end
        end
    end

    assign lbr_count = count;

endmodule

// File: tb/tb_lbr_record_unit.sv
// Directed, table-driven bench for the LBR record unit.
module tb_lbr_record_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        record_valid = 1'b0;
    logic        record_taken = 1'b0;
    logic        record_stall = 1'b0;
    logic [31:0] record_from_pc = '0;
    logic [31:0] record_to_pc = '0;
    logic        lbr_clear = 1'b0;
    logic        read_valid = 1'b0;
    logic [4:0]  read_index = '0;
    logic        read_select = 1'b0;
    logic [31:0] read_data;
    logic        read_hit;
    logic        read_data_valid;
    logic [4:0]  lbr_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [4:0]  idx;
        logic        sel;
        logic        hit;
        logic [31:0] data;
    } rd_vec_t;

    rd_vec_t small_tbl [5];
    rd_vec_t wrap_tbl  [5];

    lbr_record_unit #(
        .ADDRESS_BITS (32),
        .DEPTH        (16),
        .INDEX_BITS   (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .record_valid    (record_valid),
        .record_taken    (record_taken),
        .record_stall    (record_stall),
        .record_from_pc  (record_from_pc),
        .record_to_pc    (record_to_pc),
        .lbr_clear       (lbr_clear),
        .read_valid      (read_valid),
        .read_index      (read_index),
        .read_select     (read_select),
        .read_data       (read_data),
        .read_hit        (read_hit),
        .read_data_valid (read_data_valid),
        .lbr_count       (lbr_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic record(input logic [31:0] from_pc, input logic [31:0] to_pc);
        record_valid   = 1'b1;
        record_taken   = 1'b1;
        record_from_pc = from_pc;
        record_to_pc   = to_pc;
        step();
        record_valid   = 1'b0;
        record_taken   = 1'b0;
    endtask

    task automatic do_read(input string name, input rd_vec_t v);
        read_valid  = 1'b1;
        read_index  = v.idx;
        read_select = v.sel;
        step();
        read_valid  = 1'b0;
        check({name, "_valid"}, 32'(read_data_valid), 32'd1);
        check({name, "_hit"},   32'(read_hit),        32'(v.hit));
        check({name, "_data"},  read_data,            v.data);
    endtask

    initial begin
        small_tbl[0] = '{5'd0, 1'b1, 1'b1, 32'h400};
        small_tbl[1] = '{5'd2, 1'b0, 1'b1, 32'h100};
        small_tbl[2] = '{5'd3, 1'b0, 1'b0, 32'h0};
        small_tbl[3] = '{5'd1, 1'b0, 1'b1, 32'h104};
        small_tbl[4] = '{5'd1, 1'b1, 1'b1, 32'h300};

        wrap_tbl[0] = '{5'd0,  1'b0, 1'b1, 32'h104C};
        wrap_tbl[1] = '{5'd15, 1'b0, 1'b1, 32'h1010};
        wrap_tbl[2] = '{5'd16, 1'b0, 1'b0, 32'h0};
        wrap_tbl[3] = '{5'd31, 1'b1, 1'b0, 32'h0};
        wrap_tbl[4] = '{5'd0,  1'b1, 1'b1, 32'h204C};

        // Reset state
        step(); step();
        check("rst_valid", 32'(read_data_valid), 32'd0);
        check("rst_hit",   32'(read_hit),        32'd0);
        check("rst_data",  read_data,            32'd0);
        check("rst_count", 32'(lbr_count),       32'd0);
        reset = 1'b0;

        do_read("empty", '{5'd0, 1'b0, 1'b0, 32'h0});
        check("empty_count", 32'(lbr_count), 32'd0);

        record(32'h100, 32'h200);
        record(32'h104, 32'h300);
        record(32'h108, 32'h400);
        check("three_count", 32'(lbr_count), 32'd3);
        for (int i = 0; i < 5; i++) do_read($sformatf("small%0d", i), small_tbl[i]);

        // No read this cycle: valid drops, data/hit hold from last read
        step();
        check("hold_valid", 32'(read_data_valid), 32'd0);
        check("hold_data",  read_data,            32'h300);
        check("hold_hit",   32'(read_hit),        32'd1);

        // Filtering: not taken, then stalled taken held for 3 cycles
        record_valid = 1'b1; record_taken = 1'b0;
        record_from_pc = 32'hDEAD; record_to_pc = 32'hBEEF;
        step();
        record_taken = 1'b1; record_stall = 1'b1;
        step(); step(); step();
        record_valid = 1'b0; record_taken = 1'b0; record_stall = 1'b0;
        check("filt_count", 32'(lbr_count), 32'd3);
        do_read("filt_idx0", '{5'd0, 1'b1, 1'b1, 32'h400});
        do_read("filt_idx3", '{5'd3, 1'b0, 1'b0, 32'h0});

        // Wrap-around after a clear
        lbr_clear = 1'b1; step(); lbr_clear = 1'b0;
        check("clear_count", 32'(lbr_count), 32'd0);
        for (int k = 0; k < 20; k++) record(32'h1000 + 32'(4 * k), 32'h2000 + 32'(4 * k));
        check("wrap_count", 32'(lbr_count), 32'd16);
        for (int i = 0; i < 5; i++) do_read($sformatf("wrap%0d", i), wrap_tbl[i]);

        // Simultaneous record + read
        lbr_clear = 1'b1; step(); lbr_clear = 1'b0;
        record(32'h10, 32'h20);
        record(32'h30, 32'h40);
        record_valid = 1'b1; record_taken = 1'b1;
        record_from_pc = 32'h48; record_to_pc = 32'h50;
        do_read("simrec", '{5'd0, 1'b1, 1'b1, 32'h40});
        record_valid = 1'b0; record_taken = 1'b0;
        check("simrec_count", 32'(lbr_count), 32'd3);
        do_read("after_simrec", '{5'd0, 1'b1, 1'b1, 32'h50});

        // Simultaneous clear + record + read: read sees old state, record dropped
        lbr_clear = 1'b1; record_valid = 1'b1; record_taken = 1'b1;
        record_from_pc = 32'h60; record_to_pc = 32'h70;
        do_read("simclr", '{5'd2, 1'b0, 1'b1, 32'h10});
        lbr_clear = 1'b0; record_valid = 1'b0; record_taken = 1'b0;
        check("simclr_count", 32'(lbr_count), 32'd0);
        do_read("simclr_after", '{5'd0, 1'b1, 1'b0, 32'h0});
        record(32'h80, 32'h90);
        do_read("post_clear_rec", '{5'd0, 1'b0, 1'b1, 32'h80});

        // Reset in the same cycle as a read
        read_valid = 1'b1; read_index = 5'd0; read_select = 1'b1; reset = 1'b1;
        step();
        read_valid = 1'b0; reset = 1'b0;
        check("rstrd_valid", 32'(read_data_valid), 32'd0);
        check("rstrd_count", 32'(lbr_count),       32'd0);
        check("rstrd_data",  read_data,            32'd0);

        // Back-to-back reads: results on consecutive cycles
        record(32'hA0, 32'hB0);
        record(32'hA4, 32'hB4);
        record(32'hA8, 32'hB8);
        read_valid = 1'b1; read_select = 1'b0;
        for (int i = 0; i < 3; i++) begin
            read_index = 5'(i);
            step();
            check($sformatf("b2b%0d_valid", i), 32'(read_data_valid), 32'd1);
            check($sformatf("b2b%0d_data", i),  read_data,            32'hA8 - 32'(4 * i));
        end
        read_valid = 1'b0;
        step();
        check("b2b_end_valid", 32'(read_data_valid), 32'd0);
        check("b2b_end_data",  read_data,            32'hA0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
